// File: rtl/ex_stage.sv
// ---------------------------------------------------------------------------
// ex_stage
//
// Execute stage of the 5-stage RV32I pipeline. Holds the ID/EX pipeline
// register, forwards operands from the MEM and WB stages, runs the ALU,
// resolves branches/jumps and registers results into EX/MEM.
//
// Parameters:
//   XLEN            datapath width (only 32 is supported)
//
// Ports:
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   stall           freeze both ID/EX and EX/MEM registers
//   flush           load a bubble into ID/EX (wins over stall)
//   id_*            decoded instruction fields and control from ID
//   wb_rd, wb_reg_write, wb_result
//                   WB-stage writeback, used as a forwarding source
//   pc_src          redirect fetch (combinational, from the instruction in EX)
//   pc_target       redirect address (combinational)
//   ex_rs1/rs2/rd   ID/EX register indices for the hazard unit
//   ex_is_load      instruction in EX is a load (result_src == 01)
//   mem_*           EX/MEM pipeline register outputs
// ---------------------------------------------------------------------------
module ex_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            flush,
  input  logic [XLEN-1:0] id_rd1,
  input  logic [XLEN-1:0] id_rd2,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_imm,
  input  logic [XLEN-1:0] id_pc_plus4,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic [4:0]      id_rd,
  input  logic [2:0]      id_funct3,
  input  logic [3:0]      id_alu_control,
  input  logic            id_alu_src,
  input  logic            id_reg_write,
  input  logic            id_mem_write,
  input  logic            id_branch,
  input  logic            id_jump,
  input  logic            id_jalr,
  input  logic [1:0]      id_result_src,
  input  logic [4:0]      wb_rd,
  input  logic            wb_reg_write,
  input  logic [XLEN-1:0] wb_result,
  output logic            pc_src,
  output logic [XLEN-1:0] pc_target,
  output logic [4:0]      ex_rs1,
  output logic [4:0]      ex_rs2,
  output logic [4:0]      ex_rd,
  output logic            ex_is_load,
  output logic [XLEN-1:0] mem_alu_result,
  output logic [XLEN-1:0] mem_write_data,
  output logic [XLEN-1:0] mem_pc_plus4,
  output logic [4:0]      mem_rd,
  output logic [2:0]      mem_funct3,
  output logic            mem_reg_write,
  output logic            mem_mem_write,
  output logic [1:0]      mem_result_src
);

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_AND  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SLL  = 4'b0101,
    ALU_SRL  = 4'b0110,
    ALU_SRA  = 4'b0111,
    ALU_SLT  = 4'b1000,
    ALU_SLTU = 4'b1001
  } alu_op_e;

  // ID/EX register fields not exported as ports
  logic [XLEN-1:0] ex_rd1;
  logic [XLEN-1:0] ex_rd2;
  logic [XLEN-1:0] ex_pc;
  logic [XLEN-1:0] ex_imm;
  logic [XLEN-1:0] ex_pc_plus4;
  logic [2:0]      ex_funct3;
  logic [3:0]      ex_alu_control;
  logic            ex_alu_src;
  logic            ex_reg_write;
  logic            ex_mem_write;
  logic            ex_branch;
  logic            ex_jump;
  logic            ex_jalr;
  logic [1:0]      ex_result_src;

  // Execute-stage datapath
  logic [XLEN-1:0] fwd_a;
  logic [XLEN-1:0] fwd_b;
  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] src_b;
  logic [XLEN-1:0] alu_result;
  logic [XLEN-1:0] jalr_sum;
  logic [4:0]      shamt;
  logic            zero;
  logic            branch_cond;

  // ID/EX register. A flush clears every field, which both cancels the
  // instruction (control bits and rd become 0) and keeps the bubble's
  // source indices at x0 so it never looks like a hazard. Flush wins
  // over stall so a squashed instruction cannot be held in EX.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_rd1         <= '0;
      ex_rd2         <= '0;
      ex_pc          <= '0;
      ex_imm         <= '0;
      ex_pc_plus4    <= '0;
      ex_rs1         <= '0;
      ex_rs2         <= '0;
      ex_rd          <= '0;
      ex_funct3      <= '0;
      ex_alu_control <= '0;
      ex_alu_src     <= 1'b0;
      ex_reg_write   <= 1'b0;
      ex_mem_write   <= 1'b0;
      ex_branch      <= 1'b0;
      ex_jump        <= 1'b0;
      ex_jalr        <= 1'b0;
      ex_result_src  <= '0;
    end else if (flush) begin
      ex_rd1         <= '0;
      ex_rd2         <= '0;
      ex_pc          <= '0;
      ex_imm         <= '0;
      ex_pc_plus4    <= '0;
      ex_rs1         <= '0;
      ex_rs2         <= '0;
      ex_rd          <= '0;
      ex_funct3      <= '0;
      ex_alu_control <= '0;
      ex_alu_src     <= 1'b0;
      ex_reg_write   <= 1'b0;
      ex_mem_write   <= 1'b0;
      ex_branch      <= 1'b0;
      ex_jump        <= 1'b0;
      ex_jalr        <= 1'b0;
      ex_result_src  <= '0;
    end else if (!stall) begin
      ex_rd1         <= id_rd1;
      ex_rd2         <= id_rd2;
      ex_pc          <= id_pc;
      ex_imm         <= id_imm;
      ex_pc_plus4    <= id_pc_plus4;
      ex_rs1         <= id_rs1;
      ex_rs2         <= id_rs2;
      ex_rd          <= id_rd;
      ex_funct3      <= id_funct3;
      ex_alu_control <= id_alu_control;
      ex_alu_src     <= id_alu_src;
      ex_reg_write   <= id_reg_write;
      ex_mem_write   <= id_mem_write;
      ex_branch      <= id_branch;
      ex_jump        <= id_jump;
      ex_jalr        <= id_jalr;
      ex_result_src  <= id_result_src;
    end
  end

  assign ex_is_load = (ex_result_src == 2'b01);

  // Operand forwarding. MEM holds the younger result, so it is checked
  // first; x0 is hard-wired zero and is never a forwarding match.
  always_comb begin
    fwd_a = ex_rd1;
    if (mem_reg_write && (mem_rd != 5'd0) && (mem_rd == ex_rs1))
      fwd_a = mem_alu_result;
    else if (wb_reg_write && (wb_rd != 5'd0) && (wb_rd == ex_rs1))
      fwd_a = wb_result;
  end

  always_comb begin
    fwd_b = ex_rd2;
    if (mem_reg_write && (mem_rd != 5'd0) && (mem_rd == ex_rs2))
      fwd_b = mem_alu_result;
    else if (wb_reg_write && (wb_rd != 5'd0) && (wb_rd == ex_rs2))
      fwd_b = wb_result;
  end

  assign src_a = fwd_a;
  assign src_b = ex_alu_src ? ex_imm : fwd_b;
  assign shamt = src_b[4:0];

  // ALU. Unused codes return 0; arithmetic wraps modulo 2^XLEN.
  always_comb begin
    alu_result = '0;
    case (ex_alu_control)
      ALU_ADD:  alu_result = src_a + src_b;
      ALU_SUB:  alu_result = src_a - src_b;
      ALU_AND:  alu_result = src_a & src_b;
      ALU_OR:   alu_result = src_a | src_b;
      ALU_XOR:  alu_result = src_a ^ src_b;
      ALU_SLL:  alu_result = src_a << shamt;
      ALU_SRL:  alu_result = src_a >> shamt;
      ALU_SRA:  alu_result = $signed(src_a) >>> shamt;
      ALU_SLT:  alu_result = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      ALU_SLTU: alu_result = {{(XLEN-1){1'b0}}, (src_a < src_b)};
      default:  alu_result = '0;
    endcase
  end

  assign zero = (alu_result == '0);

  // Branch condition. beq/bne rely on the ALU doing a subtract; the
  // less-than family relies on the ALU doing slt/sltu, so bit 0 of the
  // result is the comparison outcome.
  always_comb begin
    branch_cond = 1'b0;
    case (ex_funct3)
      3'b000:         branch_cond = zero;
      3'b001:         branch_cond = !zero;
      3'b100, 3'b110: branch_cond = alu_result[0];
      3'b101, 3'b111: branch_cond = !alu_result[0];
      default:        branch_cond = 1'b0;
    endcase
  end

  assign pc_src = ex_jump | (ex_branch & branch_cond);

  // jalr targets use the forwarded rs1 and drop bit 0; everything else
  // is PC-relative.
  assign jalr_sum  = src_a + ex_imm;
  assign pc_target = ex_jalr ? {jalr_sum[XLEN-1:1], 1'b0} : (ex_pc + ex_imm);

  // EX/MEM register. Store data is the forwarded rs2, not the immediate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_alu_result <= '0;
      mem_write_data <= '0;
      mem_pc_plus4   <= '0;
      mem_rd         <= '0;
      mem_funct3     <= '0;
      mem_reg_write  <= 1'b0;
      mem_mem_write  <= 1'b0;
      mem_result_src <= '0;
    end else if (!stall) begin
      mem_alu_result <= alu_result;
      mem_write_data <= fwd_b;
      mem_pc_plus4   <= ex_pc_plus4;
      mem_rd         <= ex_rd;
      mem_funct3     <= ex_funct3;
      mem_reg_write  <= ex_reg_write;
      mem_mem_write  <= ex_mem_write;
      mem_result_src <= ex_result_src;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// ---------------------------------------------------------------------------
// tb_ex_stage
//
// Directed testbench for ex_stage. Instructions are presented on the id_*
// inputs just after a rising edge; one edge later they sit in EX (pc_src,
// pc_target, ex_* are checked), one more edge later their results are on
// the mem_* outputs.
// ---------------------------------------------------------------------------
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        flush;
  logic [31:0] id_rd1;
  logic [31:0] id_rd2;
  logic [31:0] id_pc;
  logic [31:0] id_imm;
  logic [31:0] id_pc_plus4;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic [4:0]  id_rd;
  logic [2:0]  id_funct3;
  logic [3:0]  id_alu_control;
  logic        id_alu_src;
  logic        id_reg_write;
  logic        id_mem_write;
  logic        id_branch;
  logic        id_jump;
  logic        id_jalr;
  logic [1:0]  id_result_src;
  logic [4:0]  wb_rd;
  logic        wb_reg_write;
  logic [31:0] wb_result;
  logic        pc_src;
  logic [31:0] pc_target;
  logic [4:0]  ex_rs1;
  logic [4:0]  ex_rs2;
  logic [4:0]  ex_rd;
  logic        ex_is_load;
  logic [31:0] mem_alu_result;
  logic [31:0] mem_write_data;
  logic [31:0] mem_pc_plus4;
  logic [4:0]  mem_rd;
  logic [2:0]  mem_funct3;
  logic        mem_reg_write;
  logic        mem_mem_write;
  logic [1:0]  mem_result_src;

  int testsRun    = 0;
  int testsFailed = 0;

  // ALU edge-case vectors: code, operand A, operand B, expected result
  logic [3:0]  aluCode [10] = '{4'b0111, 4'b0110, 4'b0101, 4'b0000, 4'b1111,
                                4'b0010, 4'b0100, 4'b1000, 4'b1001, 4'b0001};
  logic [31:0] aluA    [10] = '{32'h8000_0000, 32'h8000_0000, 32'h1, 32'hFFFF_FFFF, 32'h5,
                                32'hF0F0, 32'hF0F0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0};
  logic [31:0] aluB    [10] = '{32'd4, 32'd4, 32'd33, 32'd1, 32'd3,
                                32'hFF00, 32'hFF00, 32'd1, 32'd1, 32'd1};
  logic [31:0] aluExp  [10] = '{32'hF800_0000, 32'h0800_0000, 32'h2, 32'h0, 32'h0,
                                32'hF000, 32'h0FF0, 32'h1, 32'h0, 32'hFFFF_FFFF};

  ex_stage #(.XLEN(32)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .flush          (flush),
    .id_rd1         (id_rd1),
    .id_rd2         (id_rd2),
    .id_pc          (id_pc),
    .id_imm         (id_imm),
    .id_pc_plus4    (id_pc_plus4),
    .id_rs1         (id_rs1),
    .id_rs2         (id_rs2),
    .id_rd          (id_rd),
    .id_funct3      (id_funct3),
    .id_alu_control (id_alu_control),
    .id_alu_src     (id_alu_src),
    .id_reg_write   (id_reg_write),
    .id_mem_write   (id_mem_write),
    .id_branch      (id_branch),
    .id_jump        (id_jump),
    .id_jalr        (id_jalr),
    .id_result_src  (id_result_src),
    .wb_rd          (wb_rd),
    .wb_reg_write   (wb_reg_write),
    .wb_result      (wb_result),
    .pc_src         (pc_src),
    .pc_target      (pc_target),
    .ex_rs1         (ex_rs1),
    .ex_rs2         (ex_rs2),
    .ex_rd          (ex_rd),
    .ex_is_load     (ex_is_load),
    .mem_alu_result (mem_alu_result),
    .mem_write_data (mem_write_data),
    .mem_pc_plus4   (mem_pc_plus4),
    .mem_rd         (mem_rd),
    .mem_funct3     (mem_funct3),
    .mem_reg_write  (mem_reg_write),
    .mem_mem_write  (mem_mem_write),
    .mem_result_src (mem_result_src)
  );

  // 10-unit clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  // Count one comparison and report it if the observed value is wrong
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Present one decoded instruction on the id_* inputs (PC fields are set directly)
  task automatic applyStimulus(input logic [3:0] alu, input logic asrc,
                               input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                               input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                               input logic [2:0] f3, input logic rw, input logic mw,
                               input logic br, input logic jmp, input logic jr,
                               input logic [1:0] rsrc);
    id_alu_control = alu;
    id_alu_src     = asrc;
    id_rd1         = a;
    id_rd2         = b;
    id_imm         = imm;
    id_rs1         = rs1;
    id_rs2         = rs2;
    id_rd          = rd;
    id_funct3      = f3;
    id_reg_write   = rw;
    id_mem_write   = mw;
    id_branch      = br;
    id_jump        = jmp;
    id_jalr        = jr;
    id_result_src  = rsrc;
  endtask

  // Advance to just after the next rising edge
  task automatic clockCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic setWb(input logic [4:0] rd, input logic rw, input logic [31:0] res);
    wb_rd        = rd;
    wb_reg_write = rw;
    wb_result    = res;
  endtask

  // Push a do-nothing instruction through one edge
  task automatic bubble();
    applyStimulus(4'd0, 1'b0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0, 3'd0,
                  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    clockCycle();
  endtask

  initial begin
    stall       = 1'b0;
    flush       = 1'b0;
    id_pc       = 32'd0;
    id_pc_plus4 = 32'd0;
    setWb(5'd0, 1'b0, 32'd0);
    applyStimulus(4'd0, 1'b0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0, 3'd0,
                  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);

    // Reset before any clock edge
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    checkOutput("reset_mem_alu", mem_alu_result, 32'd0);
    checkOutput("reset_mem_rw", mem_reg_write, 32'd0);
    checkOutput("reset_pc_src", pc_src, 32'd0);
    checkOutput("reset_pc_target", pc_target, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    clockCycle();

    // Back-to-back forwarding: x1=5+7, x2=x1-2, x3=x1|x2
    applyStimulus(4'b0000, 1'b0, 32'd5, 32'd7, 32'd0, 5'd5, 5'd6, 5'd1, 3'd0,
                  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    clockCycle();
    checkOutput("ex_rd_add", ex_rd, 32'd1);
    applyStimulus(4'b0001, 1'b0, 32'd99, 32'd2, 32'd0, 5'd1, 5'd7, 5'd2, 3'd0,
                  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    clockCycle();
    checkOutput("fwd_add_result", mem_alu_result, 32'd12);
    applyStimulus(4'b0011, 1'b0, 32'd0, 32'd0, 32'd0, 5'd1, 5'd2, 5'd3, 3'd0,
                  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    clockCycle();
    setWb(5'd1, 1'b1, 32'd12);
    checkOutput("fwd_sub_mem", mem_alu_result, 32'd10);
    bubble();
    checkOutput("fwd_or_wb", mem_alu_result, 32'd14);
    setWb(5'd0, 1'b0, 32'd0);

    // MEM wins over WB for the same register
    applyStimulus(4'b0000, 1'b0, 32'd100, 32'd0, 32'd0, 5'd20, 5'd0, 5'd3, 3'd0,
                  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    clockCycle();
    applyStimulus(4'b0000, 1'b0, 32'd7, 32'd0, 32'd0, 5'd3, 5'd0, 5'd9, 3'd0,
                  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    clockCycle();
    setWb(5'd3, 1'b1, 32'd555);
    bubble();
    checkOutput("mem_over_wb", mem_alu_result, 32'd100);
    setWb(5'd0, 1'b0, 32'd0);

    // x0 written with reg_write=1 is never forwarded
    applyStimulus(4'b0000, 1'b0, 32'd77, 32'd0, 32'd0, 5'd21, 5'd0, 5'd0, 3'd0,
                  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    clockCycle();
    applyStimulus(4'b0000, 1'b0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd10, 3'd0,
                  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    clockCycle();
    setWb(5'd0, 1'b1, 32'd88);
    checkOutput("x0_mem_value", mem_alu_result, 32'd77);
    bubble();
    checkOutput("x0_not_forwarded", mem_alu_result, 32'd0);
    setWb(5'd0, 1'b0, 32'd0);

    // beq 9 == 9 -> taken, target pc+imm
    id_pc = 32'h100;
    applyStimulus(4'b0001, 1'b0, 32'd9, 32'd9, 32'h20, 5'd11, 5'd12, 5'd0, 3'b000,
                  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
    clockCycle();
    checkOutput("beq_taken", pc_src, 32'd1);
    checkOutput("beq_target", pc_target, 32'h120);

    // blt -1 < 1 -> taken, negative offset
    id_pc = 32'h200;
    applyStimulus(4'b1000, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFF0, 5'd11, 5'd12, 5'd0, 3'b100,
                  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
    clockCycle();
    checkOutput("blt_taken", pc_src, 32'd1);
    checkOutput("blt_target", pc_target, 32'h1F0);

    // bltu 0xFFFFFFFF < 1 unsigned -> not taken
    id_pc = 32'h300;
    applyStimulus(4'b1001, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'h40, 5'd11, 5'd12, 5'd0, 3'b110,
                  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
    clockCycle();
    checkOutput("bltu_not_taken", pc_src, 32'd0);

    // bge 5 >= 3 -> taken; the same bge with flush becomes a bubble
    id_pc = 32'h340;
    applyStimulus(4'b1000, 1'b0, 32'd5, 32'd3, 32'h10, 5'd11, 5'd12, 5'd0, 3'b101,
                  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
    clockCycle();
    checkOutput("bge_taken", pc_src, 32'd1);
    applyStimulus(4'b1000, 1'b0, 32'd5, 32'd3, 32'h10, 5'd11, 5'd12, 5'd5, 3'b101,
                  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0);
    flush = 1'b1;
    clockCycle();
    flush = 1'b0;
    checkOutput("flush_pc_src", pc_src, 32'd0);
    checkOutput("flush_ex_rd", ex_rd, 32'd0);
    bubble();
    checkOutput("flush_mem_rw", mem_reg_write, 32'd0);
    checkOutput("flush_mem_mw", mem_mem_write, 32'd0);
    id_pc = 32'd0;

    // ALU edge cases, streamed back to back
    for (int i = 0; i < 10; i++) begin
      applyStimulus(aluCode[i], 1'b0, aluA[i], aluB[i], 32'd0, 5'd22, 5'd23, 5'd0, 3'd0,
                    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
      clockCycle();
      if (i > 0)
        checkOutput($sformatf("alu_vec%0d", i - 1), mem_alu_result, aluExp[i-1]);
    end
    bubble();
    checkOutput("alu_vec9", mem_alu_result, aluExp[9]);

    // jalr: srcA=0x101, imm=2 -> target 0x102; pc+4 carried to MEM
    id_pc       = 32'h400;
    id_pc_plus4 = 32'h404;
    applyStimulus(4'b0000, 1'b1, 32'h101, 32'd0, 32'd2, 5'd13, 5'd0, 5'd1, 3'd0,
                  1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'b10);
    clockCycle();
    checkOutput("jalr_pc_src", pc_src, 32'd1);
    checkOutput("jalr_target", pc_target, 32'h102);
    id_pc       = 32'd0;
    id_pc_plus4 = 32'd0;
    bubble();
    checkOutput("jalr_pc_plus4", mem_pc_plus4, 32'h404);
    checkOutput("jalr_result_src", mem_result_src, 32'd2);

    // Stall for 3 cycles with A in MEM and B in EX, C waiting in ID
    applyStimulus(4'b0000, 1'b0, 32'd1, 32'd1, 32'd0, 5'd24, 5'd25, 5'd4, 3'd0,
                  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01);
    clockCycle();
    checkOutput("load_flag", ex_is_load, 32'd1);
    applyStimulus(4'b0000, 1'b0, 32'd3, 32'd3, 32'd0, 5'd26, 5'd27, 5'd5, 3'd0,
                  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    clockCycle();
    checkOutput("stall_pre", mem_alu_result, 32'd2);
    applyStimulus(4'b0000, 1'b0, 32'd10, 32'd10, 32'd0, 5'd28, 5'd29, 5'd6, 3'd0,
                  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      clockCycle();
      checkOutput($sformatf("stall_mem%0d", c), mem_alu_result, 32'd2);
      checkOutput($sformatf("stall_ex_rd%0d", c), ex_rd, 32'd5);
    end
    stall = 1'b0;
    clockCycle();
    checkOutput("resume_b", mem_alu_result, 32'd6);
    checkOutput("resume_ex_rd", ex_rd, 32'd6);
    bubble();
    checkOutput("resume_c", mem_alu_result, 32'd20);

    // flush and stall together: ID/EX bubbles, EX/MEM holds
    applyStimulus(4'b0000, 1'b0, 32'd7, 32'd7, 32'd0, 5'd30, 5'd31, 5'd7, 3'd0,
                  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    clockCycle();
    applyStimulus(4'b0000, 1'b0, 32'd2, 32'd2, 32'd0, 5'd11, 5'd12, 5'd8, 3'd0,
                  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    clockCycle();
    flush = 1'b1;
    stall = 1'b1;
    clockCycle();
    flush = 1'b0;
    stall = 1'b0;
    checkOutput("flush_stall_mem_hold", mem_alu_result, 32'd14);
    checkOutput("flush_stall_ex_rd", ex_rd, 32'd0);
    bubble();
    checkOutput("flush_stall_dropped", mem_rd, 32'd0);

    // Reset asserted mid-stream clears everything without a clock edge
    applyStimulus(4'b0000, 1'b0, 32'd40, 32'd2, 32'd0, 5'd1, 5'd2, 5'd9, 3'd0,
                  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    clockCycle();
    id_pc = 32'h500;
    applyStimulus(4'b0000, 1'b0, 32'd0, 32'd0, 32'h30, 5'd3, 5'd4, 5'd10, 3'd0,
                  1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
    clockCycle();
    checkOutput("pre_reset_pc_src", pc_src, 32'd1);
    checkOutput("pre_reset_target", pc_target, 32'h530);
    checkOutput("pre_reset_mem", mem_alu_result, 32'd42);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_mem_alu", mem_alu_result, 32'd0);
    checkOutput("async_mem_rw", mem_reg_write, 32'd0);
    checkOutput("async_mem_rd", mem_rd, 32'd0);
    checkOutput("async_pc_src", pc_src, 32'd0);
    checkOutput("async_pc_target", pc_target, 32'd0);
    checkOutput("async_ex_rd", ex_rd, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    clockCycle();

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
